// File: rtl/io_burst_sequencer_pkg.sv
// Shared widths, direction codes and FSM encodings for the io_unit burst sequencer.
package io_burst_sequencer_pkg;

    localparam int unsigned DEF_CNT_W  = 16;
    localparam int unsigned DEF_DATA_W = 16;

    localparam logic SEQ_DIR_READ  = 1'b0;
    localparam logic SEQ_DIR_WRITE = 1'b1;

    // io_unit mode selectors for the two unit instances
    localparam logic IO_READ  = 1'b0;
    localparam logic IO_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IO_SEQ_IDLE  = 3'd0,
        IO_SEQ_FETCH = 3'd1,
        IO_SEQ_ISSUE = 3'd2,
        IO_SEQ_ARM   = 3'd3,
        IO_SEQ_WAIT  = 3'd4,
        IO_SEQ_PUSH  = 3'd5,
        IO_SEQ_DONE  = 3'd6
    } seq_state_e;

endpackage

// File: rtl/io_burst_sequencer_beat_counter.sv
// Burst beat counter: load clears the count and latches the length, last_c flags the final word.
module io_beat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             last_c
);

    logic [CNT_W-1:0] len_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count <= '0;
            len_q <= '0;
        end else if (load) begin
            count <= '0;
            len_q <= len;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    // count never exceeds len, so the +1 cannot wrap past len_q
    assign last_c = (count + CNT_W'(1)) == len_q;

endmodule

// File: rtl/io_burst_sequencer.sv
// Sequences multi-word bursts through the write and read io_unit instances.
module io_burst_sequencer
    import io_burst_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [CNT_W-1:0]  cmd_len,
    input  logic              abort,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              wio_activate,
    input  logic              wio_busy,
    input  logic              wio_init,
    output logic [DATA_W-1:0] wio_data,
    output logic              rio_activate,
    input  logic              rio_busy,
    input  logic              rio_init,
    input  logic [DATA_W-1:0] rio_data,
    output logic              done,
    output logic              aborted,
    output logic [CNT_W-1:0]  xfer_count
);

    seq_state_e state, state_nxt;
    logic dir, dir_nxt, abort_flag;
    logic accept, init_ok, abort_seen, sel_busy, issued;
    logic cnt_inc, hold_load, rd_cap, last_c;

    assign accept     = (state == IO_SEQ_IDLE) & cmd_valid & cmd_ready;
    assign init_ok    = wio_init & rio_init;
    // losing either init is handled like an abort
    assign abort_seen = abort_flag | abort | ~init_ok;
    assign dir_nxt    = accept ? cmd_dir : dir;
    assign sel_busy   = (dir == SEQ_DIR_WRITE) ? wio_busy : rio_busy;
    assign issued     = (dir == SEQ_DIR_WRITE) ? wio_activate : rio_activate;

    io_beat_counter #(.CNT_W(CNT_W)) u_beat (
        .clk    (clk),
        .nreset (nreset),
        .load   (accept),
        .len    (cmd_len),
        .inc    (cnt_inc),
        .count  (xfer_count),
        .last_c (last_c)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= IO_SEQ_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_inc   = 1'b0;
        hold_load = 1'b0;
        rd_cap    = 1'b0;
        case (state)
            IO_SEQ_IDLE: begin
                if (accept) begin
                    if (cmd_len == '0)                state_nxt = IO_SEQ_DONE;
                    else if (cmd_dir == SEQ_DIR_WRITE) state_nxt = IO_SEQ_FETCH;
                    else                               state_nxt = IO_SEQ_ISSUE;
                end
            end
            IO_SEQ_FETCH: begin
                if (wr_valid) begin
                    hold_load = 1'b1;
                    state_nxt = IO_SEQ_ISSUE;
                end else if (abort_seen) begin
                    state_nxt = IO_SEQ_DONE;
                end
            end
            IO_SEQ_ISSUE: begin
                if (issued)        state_nxt = IO_SEQ_ARM;
                else if (!init_ok) state_nxt = IO_SEQ_DONE;
            end
            // unit raises busy a cycle after activate, so skip one busy check
            IO_SEQ_ARM: state_nxt = IO_SEQ_WAIT;
            IO_SEQ_WAIT: begin
                if (!sel_busy) begin
                    if (dir == SEQ_DIR_WRITE) begin
                        cnt_inc   = 1'b1;
                        state_nxt = (last_c | abort_seen) ? IO_SEQ_DONE : IO_SEQ_FETCH;
                    end else begin
                        rd_cap    = 1'b1;
                        state_nxt = IO_SEQ_PUSH;
                    end
                end
            end
            IO_SEQ_PUSH: begin
                if (rd_ready) begin
                    cnt_inc   = 1'b1;
                    state_nxt = (last_c | abort_seen) ? IO_SEQ_DONE : IO_SEQ_ISSUE;
                end
            end
            IO_SEQ_DONE: state_nxt = IO_SEQ_IDLE;
            default:     state_nxt = IO_SEQ_IDLE;
        endcase
    end

    // registered handshakes and pulses, decoded from the upcoming state
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            dir          <= 1'b0;
            abort_flag   <= 1'b0;
            cmd_ready    <= 1'b0;
            wr_ready     <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            wio_activate <= 1'b0;
            rio_activate <= 1'b0;
            wio_data     <= '0;
            done         <= 1'b0;
            aborted      <= 1'b0;
        end else begin
            dir          <= dir_nxt;
            if (accept)
                abort_flag <= 1'b0;
            else if ((state != IO_SEQ_IDLE) && (abort || !init_ok))
                abort_flag <= 1'b1;
            cmd_ready    <= (state_nxt == IO_SEQ_IDLE) & init_ok;
            wr_ready     <= (state_nxt == IO_SEQ_FETCH);
            rd_valid     <= (state_nxt == IO_SEQ_PUSH);
            wio_activate <= (state_nxt == IO_SEQ_ISSUE) & (dir_nxt == SEQ_DIR_WRITE) & ~wio_busy;
            rio_activate <= (state_nxt == IO_SEQ_ISSUE) & (dir_nxt == SEQ_DIR_READ) & ~rio_busy;
            if (rd_cap)    rd_data  <= rio_data;
            // write unit samples data_in while idle, so hold until the word completes
            if (hold_load) wio_data <= wr_data;
            done         <= (state == IO_SEQ_DONE);
            aborted      <= (state == IO_SEQ_DONE) & abort_flag;
        end
    end

endmodule

// File: tb/tb_io_burst_sequencer.sv
// Directed bench for io_burst_sequencer with behavioural write/read io_unit models.
module tb_io_burst_sequencer;
    import io_burst_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        cmd_valid = 1'b0, cmd_dir = 1'b0, abort = 1'b0;
    logic [15:0] cmd_len = '0;
    logic        cmd_ready, wr_ready, rd_valid, wio_activate, rio_activate, done, aborted;
    logic        wr_valid = 1'b0, rd_ready = 1'b0;
    logic [15:0] wr_data = '0;
    logic [15:0] rd_data, wio_data, xfer_count;
    logic        wio_busy = 1'b0, rio_busy = 1'b0, wio_init = 1'b0, rio_init = 1'b0;
    logic [15:0] rio_data = '0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    io_burst_sequencer dut (
        .clk(clk), .nreset(nreset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir), .cmd_len(cmd_len),
        .abort(abort),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .wio_activate(wio_activate), .wio_busy(wio_busy), .wio_init(wio_init), .wio_data(wio_data),
        .rio_activate(rio_activate), .rio_busy(rio_busy), .rio_init(rio_init), .rio_data(rio_data),
        .done(done), .aborted(aborted), .xfer_count(xfer_count)
    );

    // write io_unit: busy for 3 cycles after activate, logs the word and checks data_in holds
    logic [15:0] wcap = '0;
    logic [15:0] wlog [0:15];
    int wcnt = 0, wact_n = 0, stab_err = 0;
    always @(posedge clk) begin
        if (wio_activate && !wio_busy) begin
            wio_busy <= 1'b1;
            wcnt     <= 3;
            wcap     <= wio_data;
            if (wact_n < 16) wlog[wact_n] <= wio_data;
            wact_n   <= wact_n + 1;
        end else if (wio_busy) begin
            if (wio_data !== wcap) stab_err <= stab_err + 1;
            if (wcnt == 1) wio_busy <= 1'b0;
            wcnt <= wcnt - 1;
        end
    end

    // read io_unit: presents the next table word on activate, busy for 3 cycles
    logic [15:0] rtab [0:7] = '{16'hBEEF, 16'h0F0F, 16'hC3C3, 16'h1111,
                                16'h2222, 16'h3333, 16'h4444, 16'h5555};
    int rcnt = 0, ract_n = 0;
    always @(posedge clk) begin
        if (rio_activate && !rio_busy) begin
            rio_busy <= 1'b1;
            rcnt     <= 3;
            rio_data <= rtab[ract_n % 8];
            ract_n   <= ract_n + 1;
        end else if (rio_busy) begin
            if (rcnt == 1) rio_busy <= 1'b0;
            rcnt <= rcnt - 1;
        end
    end

    int done_cnt = 0;
    logic done_ab = 1'b0;
    logic [15:0] done_xfer = '0;
    always @(posedge clk) begin
        if (done) begin
            done_cnt  <= done_cnt + 1;
            done_ab   <= aborted;
            done_xfer <= xfer_count;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic d, input logic [15:0] l);
        int k = 0;
        @(negedge clk);
        cmd_dir = d; cmd_len = l; cmd_valid = 1'b1;
        while (!cmd_ready && k < 100) begin @(negedge clk); k++; end
        chk("cmd_accept", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1 cmd_valid = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] d);
        int k = 0;
        @(negedge clk);
        wr_data = d; wr_valid = 1'b1;
        while (!wr_ready && k < 100) begin @(negedge clk); k++; end
        chk("wr_accept", 32'(wr_ready), 32'd1);
        @(posedge clk); #1 wr_valid = 1'b0;
    endtask

    task automatic pop_word(input logic [15:0] exp, input int stall);
        int k = 0;
        int bad = 0;
        int a0;
        @(negedge clk);
        while (!rd_valid && k < 100) begin @(negedge clk); k++; end
        chk("rd_valid", 32'(rd_valid), 32'd1);
        chk("rd_data", 32'(rd_data), 32'(exp));
        a0 = ract_n;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (rd_data !== exp || rd_valid !== 1'b1 || ract_n != a0) bad++;
        end
        if (stall > 0) chk("rd_stall_stable", 32'(bad), 32'd0);
        rd_ready = 1'b1;
        @(posedge clk); #1 rd_ready = 1'b0;
    endtask

    task automatic wait_done(input int n0);
        int k = 0;
        while (done_cnt == n0 && k < 300) begin @(negedge clk); k++; end
        chk("done_seen", 32'(done_cnt), 32'(n0 + 1));
    endtask

    initial begin
        int n0, w0, r0, a0, k, bad;

        // reset with both units uninitialised
        repeat (2) @(negedge clk);
        chk("rst_flags", 32'({cmd_ready, wr_ready, rd_valid, wio_activate, rio_activate, done, aborted}), 32'd0);
        chk("rst_xfer", 32'(xfer_count), 32'd0);
        @(negedge clk) nreset = 1'b1;
        bad = 0;
        repeat (16) begin @(negedge clk); if (cmd_ready !== 1'b0) bad++; end
        chk("ready_no_init", 32'(bad), 32'd0);
        wio_init = 1'b1;
        repeat (3) @(negedge clk);
        chk("ready_one_init", 32'(cmd_ready), 32'd0);
        rio_init = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_both_init", 32'(cmd_ready), 32'd1);
        chk("no_act_init", 32'(wact_n + ract_n), 32'd0);

        // 4-word write
        n0 = done_cnt;
        send_cmd(SEQ_DIR_WRITE, 16'd4);
        push_word(16'hA5A5);
        push_word(16'h1234);
        push_word(16'hFFFF);
        push_word(16'h0001);
        wait_done(n0);
        chk("wr4_acts", 32'(wact_n), 32'd4);
        chk("wr4_w0", 32'(wlog[0]), 32'h0000A5A5);
        chk("wr4_w1", 32'(wlog[1]), 32'h00001234);
        chk("wr4_w2", 32'(wlog[2]), 32'h0000FFFF);
        chk("wr4_w3", 32'(wlog[3]), 32'h00000001);
        chk("wr4_stable", 32'(stab_err), 32'd0);
        chk("wr4_xfer", 32'(done_xfer), 32'd4);
        chk("wr4_aborted", 32'(done_ab), 32'd0);

        // 3-word read with a 5-cycle sink stall on word 2
        n0 = done_cnt;
        send_cmd(SEQ_DIR_READ, 16'd3);
        pop_word(16'hBEEF, 0);
        pop_word(16'h0F0F, 5);
        pop_word(16'hC3C3, 0);
        wait_done(n0);
        chk("rd3_acts", 32'(ract_n), 32'd3);
        chk("rd3_xfer", 32'(done_xfer), 32'd3);
        chk("rd3_aborted", 32'(done_ab), 32'd0);

        // zero-length command
        a0 = wact_n + ract_n;
        send_cmd(SEQ_DIR_WRITE, 16'd0);
        @(negedge clk);
        chk("len0_early", 32'(done), 32'd0);
        @(negedge clk);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_xfer", 32'(xfer_count), 32'd0);
        chk("len0_aborted", 32'(aborted), 32'd0);
        @(negedge clk);
        chk("len0_pulse", 32'(done), 32'd0);
        chk("len0_no_act", 32'(wact_n + ract_n), 32'(a0));

        // abort during word 2 of an 8-word write
        n0 = done_cnt;
        w0 = wact_n;
        send_cmd(SEQ_DIR_WRITE, 16'd8);
        push_word(16'h0A0A);
        push_word(16'h0B0B);
        k = 0;
        while (!(wact_n == w0 + 2 && wio_busy) && k < 100) begin @(negedge clk); k++; end
        chk("abt_word2_busy", 32'(wio_busy), 32'd1);
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        wait_done(n0);
        chk("abt_xfer", 32'(done_xfer), 32'd2);
        chk("abt_aborted", 32'(done_ab), 32'd1);
        chk("abt_acts", 32'(wact_n - w0), 32'd2);
        chk("abt_w1", 32'(wlog[w0 + 1]), 32'h00000B0B);

        // reset during read word 1 busy
        n0 = done_cnt;
        r0 = ract_n;
        send_cmd(SEQ_DIR_READ, 16'd2);
        k = 0;
        while (!(ract_n == r0 + 1 && rio_busy) && k < 100) begin @(negedge clk); k++; end
        @(negedge clk) nreset = 1'b0;
        #1;
        chk("mid_rst_flags", 32'({cmd_ready, wr_ready, rd_valid, wio_activate, rio_activate, done, aborted}), 32'd0);
        chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
        chk("mid_rst_wio_data", 32'(wio_data), 32'd0);
        chk("mid_rst_xfer", 32'(xfer_count), 32'd0);
        @(negedge clk) nreset = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_no_done", 32'(done_cnt), 32'(n0));
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);

        // single-word read after reset
        n0 = done_cnt;
        send_cmd(SEQ_DIR_READ, 16'd1);
        pop_word(16'h2222, 0);
        wait_done(n0);
        chk("post_rst_xfer", 32'(done_xfer), 32'd1);
        chk("post_rst_aborted", 32'(done_ab), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/io_burst_sequencer.md
Name: io_burst_sequencer

Overview:
- Sequences multi-word data transfers through the two io_unit instances: one IO_WRITE unit and one IO_READ unit.
- Accepts a burst command (direction, length) from the NAND command FSM.
- Drives one activate pulse per word and obeys the units' busy/initialized handshake.
- Streams write data in from a valid/ready source, and read data out to a valid/ready sink.

Parameters:
- CNT_W, 16, width of burst length and transfer count.
- DATA_W, 16, data word width; must match io_unit (16).

Ports:
- clk  in  1  system clock
- nreset  in  1  asynchronous active-low reset
- cmd_valid  in  1  burst command request
- cmd_ready  out  1  sequencer can accept a command
- cmd_dir  in  1  0 = read (IO_READ unit), 1 = write (IO_WRITE unit)
- cmd_len  in  CNT_W  number of words, 0 allowed
- abort  in  1  stop after the word in flight
- wr_valid / wr_ready  in/out  1  write-data source handshake
- wr_data  in  DATA_W  write word
- rd_valid / rd_ready  out/in  1  read-data sink handshake
- rd_data  out  DATA_W  read word
- wio_activate  out  1  activate pulse to write io_unit
- wio_busy, wio_init  in  1  write io_unit busy / initialized
- wio_data  out  DATA_W  data_in of write io_unit
- rio_activate  out  1  activate pulse to read io_unit
- rio_busy, rio_init  in  1  read io_unit busy / initialized
- rio_data  in  DATA_W  data_out of read io_unit
- done  out  1  one-cycle burst-complete pulse
- aborted  out  1  valid with done; burst ended by abort
- xfer_count  out  CNT_W  words completed in the last/current burst

Behaviour:
- Reset values: all outputs 0 (cmd_ready 0, activates 0, valids 0, data 0, done 0, aborted 0, xfer_count 0); state S_IDLE.

States:
- S_IDLE: cmd_ready = wio_init & rio_init.
  - On cmd_valid & cmd_ready: latch dir and len, clear xfer_count and abort flag.
  - len == 0 -> S_DONE.
  - Otherwise write -> S_FETCH, read -> S_ISSUE.
- S_FETCH (write only): wr_ready = 1.
  - On wr_valid: latch wr_data into a hold register, drive it on wio_data -> S_ISSUE.
- S_ISSUE: assert wio_activate or rio_activate for exactly 1 cycle, only if the selected busy = 0; otherwise stall -> S_ARM.
- S_ARM: busy is ignored for this single cycle, because the unit raises busy the cycle after activate -> S_WAIT.
- S_WAIT: wait for selected busy == 0.
  - Write: xfer_count++ then go to next-word.
  - Read: capture rio_data into rd_data -> S_PUSH.
- S_PUSH (read only): rd_valid = 1, rd_data held stable until rd_ready; on handshake xfer_count++ then go to next-word.
- next-word decision: xfer_count == len or abort flag set -> S_DONE; otherwise S_FETCH (write) / S_ISSUE (read).
- S_DONE: done = 1 for one cycle, aborted = abort flag -> S_IDLE.

Data and counting rules:
- wio_data is held constant from S_FETCH exit until S_WAIT exit, because io_unit samples data_in continuously while idle.
- abort is sampled in any non-idle state into a sticky flag. It never cuts an io_unit cycle in progress, and a pending S_PUSH word is still delivered.
- abort in S_FETCH with no word accepted -> S_DONE immediately.
- abort in S_IDLE is ignored.
- Count comparison is unsigned on CNT_W bits; the maximum len 2^CNT_W-1 completes without wrap.
- Either init deasserting mid-burst is treated as a fatal abort: -> S_DONE with aborted = 1 after the current S_WAIT.
- cmd_valid outside S_IDLE is ignored (cmd_ready = 0).
- Asynchronous reset mid-burst returns to S_IDLE with no done pulse.
- Throughput: at most one word per io_unit cycle; no other pipelining.

Decomposition:
- onfi_package.v:
  - add the state encodings IO_SEQ_IDLE through IO_SEQ_DONE (3 bits);
  - add the direction constants SEQ_DIR_READ = 0 and SEQ_DIR_WRITE = 1;
  - reuse the existing IO_READ/IO_WRITE constants for instantiation in the bench.
- One sub-module: io_beat_counter (load, increment, terminal-compare against len, CNT_W wide).

Test Plan:
- Reset release with init low for 16 cycles -> cmd_ready = 0 until both init = 1; no activate issued.
- Write burst, len = 4, data 0xA5A5, 0x1234, 0xFFFF, 0x0001 -> four wio_activate pulses, each preceded by the matching wio_data stable through busy; done with xfer_count = 4, aborted = 0.
- Read burst, len = 3, rd_ready held low for 5 cycles on word 2 -> rd_data stable while stalled; no rio_activate until the handshake; xfer_count = 3.
- len = 0 command -> done pulse 2 cycles after acceptance; no activate; xfer_count = 0.
- Abort asserted during S_WAIT of word 2 of an 8-word write -> word 2 completes; done with aborted = 1, xfer_count = 2.
- nreset pulsed during read word 1's S_WAIT -> all outputs 0; new 1-word read afterwards completes normally with xfer_count = 1.
